// File: rtl/aes_decipher_block_pkg.sv
// Shared constants, FSM encoding and GF(2^8) helpers for the AES inverse cipher.
// The inverse S-box content is derived here from field inversion rather than typed in.
package aes_decipher_block_pkg;

  localparam logic       AES_128_BIT_KEY = 1'h0;
  localparam logic       AES_256_BIT_KEY = 1'h1;
  localparam logic [3:0] AES128_ROUNDS   = 4'ha;
  localparam logic [3:0] AES256_ROUNDS   = 4'he;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_SBOX  = 3'd2,
    ST_MAIN  = 3'd3,
    ST_FINAL = 3'd4
  } dec_state_e;

  function automatic logic [3:0] num_rounds(input logic keylen);
    return (keylen == AES_256_BIT_KEY) ? AES256_ROUNDS : AES128_ROUNDS;
  endfunction

  function automatic logic [7:0] gm2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm4(input logic [7:0] b);
    return gm2(gm2(b));
  endfunction

  function automatic logic [7:0] gm8(input logic [7:0] b);
    return gm2(gm4(b));
  endfunction

  function automatic logic [7:0] gm09(input logic [7:0] b);
    return gm8(b) ^ b;
  endfunction

  function automatic logic [7:0] gm11(input logic [7:0] b);
    return gm8(b) ^ gm2(b) ^ b;
  endfunction

  function automatic logic [7:0] gm13(input logic [7:0] b);
    return gm8(b) ^ gm4(b) ^ b;
  endfunction

  function automatic logic [7:0] gm14(input logic [7:0] b);
    return gm8(b) ^ gm4(b) ^ gm2(b);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = gm2(x);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse (and maps 0 to 0, as AES requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox_byte(input logic [7:0] y);
    logic [7:0] x;
    x = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    return gf_inv(x);
  endfunction

  function automatic logic [31:0] inv_mixw(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gm14(a0) ^ gm11(a1) ^ gm13(a2) ^ gm09(a3),
            gm09(a0) ^ gm14(a1) ^ gm11(a2) ^ gm13(a3),
            gm13(a0) ^ gm09(a1) ^ gm14(a2) ^ gm11(a3),
            gm11(a0) ^ gm13(a1) ^ gm09(a2) ^ gm14(a3)};
  endfunction

  function automatic logic [127:0] inv_mixcolumns(input logic [127:0] s);
    return {inv_mixw(s[127:96]), inv_mixw(s[95:64]), inv_mixw(s[63:32]), inv_mixw(s[31:0])};
  endfunction

  // Byte k = 4*col + row, byte 0 in bits 127:120; row r rotates right by r columns.
  function automatic logic [127:0] inv_shiftrows(input logic [127:0] s);
    logic [7:0] b [16];
    for (int k = 0; k < 16; k++) b[k] = s[8*(15-k) +: 8];
    return {b[0], b[13], b[10], b[7], b[4], b[1], b[14], b[11],
            b[8], b[5], b[2],  b[15], b[12], b[9], b[6], b[3]};
  endfunction

endpackage

// File: rtl/aes_decipher_block_if.sv
// Bus between the decipher block, its requester and the round-key memory.
interface aes_decipher_block_if;
  logic         next;
  logic         keylen;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [127:0] block;
  logic [127:0] new_block;
  logic         ready;

  modport master (output next, keylen, round_key, block, input round, new_block, ready);
  modport slave  (input next, keylen, round_key, block, output round, new_block, ready);
endinterface

// File: rtl/aes_inv_sbox.sv
// Combinational inverse S-box for one 32-bit word: four parallel 256-entry byte lookups.
module aes_inv_sbox
  import aes_decipher_block_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  logic [7:0] w_table [256];

  // Table is a constant function of the index, so it folds into a ROM.
  for (genvar gi = 0; gi < 256; gi++) begin : g_table
    assign w_table[gi] = inv_sbox_byte(8'(gi));
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign o_word[8*gi +: 8] = w_table[i_word[8*gi +: 8]];
  end

endmodule

// File: rtl/aes_decipher_block.sv
// Iterative AES-128/256 inverse cipher; one inverse-S-box word per cycle,
// round keys looked up combinationally from the registered round index.
module aes_decipher_block
  import aes_decipher_block_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  aes_decipher_block_if.slave  bus
);

  dec_state_e   r_state, w_state_next;
  logic [127:0] r_blk, w_blk_next;
  logic [3:0]   r_round_ctr, w_round_next;
  logic [1:0]   r_word_ctr, w_word_next;
  logic         r_keylen, w_keylen_next;
  logic         r_ready, w_ready_next;
  logic [6:0]   w_word_lsb;
  logic [31:0]  w_sbox_in, w_sbox_out;

  // Word 0 sits in the top 32 bits, so the word offset is (3 - ctr) * 32.
  assign w_word_lsb = {~r_word_ctr, 5'b0};
  assign w_sbox_in  = r_blk[w_word_lsb +: 32];

  aes_inv_sbox u_inv_sbox (
    .i_word (w_sbox_in),
    .o_word (w_sbox_out)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_blk       <= '0;
      r_round_ctr <= '0;
      r_word_ctr  <= '0;
      r_keylen    <= AES_128_BIT_KEY;
      r_ready     <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_blk       <= w_blk_next;
      r_round_ctr <= w_round_next;
      r_word_ctr  <= w_word_next;
      r_keylen    <= w_keylen_next;
      r_ready     <= w_ready_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_blk_next    = r_blk;
    w_round_next  = r_round_ctr;
    w_word_next   = r_word_ctr;
    w_keylen_next = r_keylen;
    w_ready_next  = r_ready;

    case (r_state)
      ST_IDLE: begin
        if (bus.next) begin
          w_ready_next  = 1'b0;
          w_round_next  = num_rounds(bus.keylen);
          w_keylen_next = bus.keylen;
          w_state_next  = ST_INIT;
        end
      end
      ST_INIT: begin
        w_blk_next   = inv_shiftrows(bus.block ^ bus.round_key);
        w_round_next = num_rounds(r_keylen) - 4'd1;
        w_word_next  = 2'd0;
        w_state_next = ST_SBOX;
      end
      ST_SBOX: begin
        w_blk_next[w_word_lsb +: 32] = w_sbox_out;
        w_word_next = r_word_ctr + 2'd1;
        if (r_word_ctr == 2'd3) begin
          w_state_next = (r_round_ctr != 4'd0) ? ST_MAIN : ST_FINAL;
        end
      end
      ST_MAIN: begin
        w_blk_next   = inv_shiftrows(inv_mixcolumns(r_blk ^ bus.round_key));
        w_round_next = r_round_ctr - 4'd1;
        w_word_next  = 2'd0;
        w_state_next = ST_SBOX;
      end
      ST_FINAL: begin
        w_blk_next   = r_blk ^ bus.round_key;
        w_ready_next = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.round     = r_round_ctr;
  assign bus.new_block = r_blk;
  assign bus.ready     = r_ready;

endmodule

// File: tb/tb_aes_decipher_block.sv
// Bench for aes_decipher_block: FIPS-197 vectors, corner sequences and random
// blocks whose ciphertext comes from a forward-cipher model kept here.
module tb_aes_decipher_block;
  import aes_decipher_block_pkg::*;

  logic clk;
  logic reset_n;
  aes_decipher_block_if bus ();

  aes_decipher_block dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key memory: zero-cycle lookup by the DUT's round index.
  logic [127:0] rk_mem [16];
  assign bus.round_key = rk_mem[bus.round];

  int checks;
  int errors;
  int rnd_q [$];
  logic [7:0] sb [256];

  typedef struct {
    logic         kl;
    logic [255:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    int           lat;
  } vec_t;

  vec_t vecs [3];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Forward S-box: inverse found by exhaustive search, then the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
              {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key, input logic kl);
    logic [31:0] w [60];
    logic [31:0] tmp;
    logic [7:0]  rcon;
    int nk, nr;
    nk = kl ? 8 : 4;
    nr = kl ? 14 : 10;
    rcon = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp  = subw({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int r = 0; r < 16; r++)
      rk_mem[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ rk_mem[0][127-8*k -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int k = 0; k < 16; k++) t[k] = sb[s[k]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          s[4*c+rr] = t[4*((c+rr)%4)+rr];
      if (r != nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = mul(8'h02, a0) ^ mul(8'h03, a1) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ mul(8'h02, a1) ^ mul(8'h03, a2) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ mul(8'h02, a2) ^ mul(8'h03, a3);
          s[4*c+3] = mul(8'h03, a0) ^ a1 ^ a2 ^ mul(8'h02, a3);
        end
      end
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ rk_mem[r][127-8*k -: 8];
    end
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = s[k];
    return o;
  endfunction

  task automatic start_op(input logic kl, input logic [127:0] blk, input bit hold);
    @(negedge clk);
    bus.next   = 1'b1;
    bus.keylen = kl;
    bus.block  = blk;
    @(posedge clk);
    #1;
    chk("accept", 128'(bus.ready), 128'h0);
    if (!hold) bus.next = 1'b0;
  endtask

  // Counts edges after the accepting edge until ready is seen high again.
  task automatic wait_ready(input bit disturb, input int abort_at, output int n);
    n = 0;
    rnd_q.delete();
    while (bus.ready !== 1'b1) begin
      if (n == abort_at) return;
      if (n >= 200) begin
        checks++;
        errors++;
        $display("FAIL timeout: ready still low after %0d cycles, required within 200", n);
        return;
      end
      rnd_q.push_back(int'(bus.round));
      @(negedge clk);
      if (disturb && n >= 1) begin
        bus.next   = 1'($urandom_range(0, 1));
        bus.keylen = ~bus.keylen;
        bus.block  = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (disturb) bus.next = 1'b0;
  endtask

  task automatic run_vec(input string tag, input logic kl, input logic [255:0] key,
                         input logic [127:0] ct, input logic [127:0] pt, input bit disturb);
    int n;
    expand(key, kl);
    start_op(kl, ct, 1'b0);
    wait_ready(disturb, -1, n);
    $display("run %s keylen=%0d latency=%0d result=%h", tag, kl, n, bus.new_block);
    chk({tag, "_out"}, bus.new_block, pt);
    chk({tag, "_lat"}, 128'(n), 128'(kl ? 71 : 51));
  endtask

  localparam logic [127:0] PT_C    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY_C1  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY_C3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY_B   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};

  initial begin
    int n;
    int exp_q [$];
    bit bad;
    logic kl;
    logic [255:0] key;
    logic [127:0] pt;
    logic [127:0] ct;

    checks = 0;
    errors = 0;
    bus.next = 1'b0;
    bus.keylen = AES_128_BIT_KEY;
    bus.block = 128'h0;
    for (int r = 0; r < 16; r++) rk_mem[r] = 128'h0;
    build_sbox();

    vecs[0] = '{AES_128_BIT_KEY, KEY_C1, CT_C1, PT_C, 51};
    vecs[1] = '{AES_256_BIT_KEY, KEY_C3, CT_C3, PT_C, 71};
    vecs[2] = '{AES_128_BIT_KEY, KEY_B, 128'h3925841d02dc09fbdc118597196a0b32,
                128'h3243f6a8885a308d313198a2e0370734, 51};

    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 128'(bus.ready), 128'h1);
    chk("rst_block", bus.new_block, 128'h0);
    chk("rst_round", 128'(bus.round), 128'h0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      expand(vecs[i].key, vecs[i].kl);
      start_op(vecs[i].kl, vecs[i].ct, 1'b0);
      wait_ready(1'b0, -1, n);
      $display("run vec%0d keylen=%0d latency=%0d result=%h", i, vecs[i].kl, n, bus.new_block);
      chk("vec_out", bus.new_block, vecs[i].pt);
      chk("vec_lat", 128'(n), 128'(vecs[i].lat));
      if (i == 2) begin
        exp_q.delete();
        exp_q.push_back(10);
        for (int r = 9; r >= 0; r--)
          for (int j = 0; j < 5; j++) exp_q.push_back(r);
        bad = (rnd_q.size() != exp_q.size());
        if (!bad)
          for (int j = 0; j < exp_q.size(); j++)
            if (rnd_q[j] != exp_q[j]) bad = 1'b1;
        checks++;
        if (bad) begin
          errors++;
          $display("FAIL round_seq: got %0d samples starting %0d, expected %0d samples 10,9x5..0x5",
                   rnd_q.size(), (rnd_q.size() > 0) ? rnd_q[0] : -1, exp_q.size());
        end
      end
    end

    // Output must hold while idle.
    repeat (3) @(posedge clk);
    #1;
    chk("idle_hold", bus.new_block, vecs[2].pt);

    run_vec("disturb", AES_128_BIT_KEY, KEY_C1, CT_C1, PT_C, 1'b1);

    // Reset asserted mid-run, then a fresh request on the release edge.
    expand(KEY_C1, AES_128_BIT_KEY);
    start_op(AES_128_BIT_KEY, CT_C1, 1'b0);
    wait_ready(1'b0, 20, n);
    #3;
    reset_n = 1'b0;
    #1;
    chk("midrst_ready", 128'(bus.ready), 128'h1);
    chk("midrst_block", bus.new_block, 128'h0);
    chk("midrst_round", 128'(bus.round), 128'h0);
    @(negedge clk);
    reset_n    = 1'b1;
    bus.next   = 1'b1;
    bus.keylen = AES_128_BIT_KEY;
    bus.block  = CT_C1;
    @(posedge clk);
    #1;
    chk("postrst_accept", 128'(bus.ready), 128'h0);
    bus.next = 1'b0;
    wait_ready(1'b0, -1, n);
    $display("run postrst keylen=0 latency=%0d result=%h", n, bus.new_block);
    chk("postrst_out", bus.new_block, PT_C);
    chk("postrst_lat", 128'(n), 128'd51);

    // Back-to-back with next held: C.1 then C.3 with no dead cycle.
    expand(KEY_C1, AES_128_BIT_KEY);
    start_op(AES_128_BIT_KEY, CT_C1, 1'b1);
    wait_ready(1'b0, -1, n);
    $display("run b2b_first keylen=0 latency=%0d result=%h", n, bus.new_block);
    chk("b2b1_out", bus.new_block, PT_C);
    chk("b2b1_lat", 128'(n), 128'd51);
    expand(KEY_C3, AES_256_BIT_KEY);
    bus.keylen = AES_256_BIT_KEY;
    bus.block  = CT_C3;
    @(posedge clk);
    #1;
    chk("b2b_restart", 128'(bus.ready), 128'h0);
    bus.next = 1'b0;
    wait_ready(1'b0, -1, n);
    $display("run b2b_second keylen=1 latency=%0d result=%h", n, bus.new_block);
    chk("b2b2_out", bus.new_block, PT_C);
    chk("b2b2_lat", 128'(n), 128'd71);

    for (int i = 0; i < 6; i++) begin
      kl  = 1'($urandom_range(0, 1));
      key = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
      if (!kl) key[127:0] = 128'h0;
      pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
      expand(key, kl);
      ct  = encrypt(pt, kl ? 14 : 10);
      run_vec("random", kl, key, ct, pt, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
